// File: rtl/done_monitor_pkg.sv
// done_monitor_pkg: state/cause encodings and shared widths for the completion monitor
package done_monitor_pkg;
  localparam int FAIL_CNT_W = 8;
  // every pair of legal states differs in at least two bits
  typedef enum logic [3:0] {
    S_IDLE = 4'b0000,
    S_WAIT = 4'b0011,
    S_PASS = 4'b0101,
    S_FAIL = 4'b0110
  } mon_state_e;
  typedef enum logic [2:0] {
    C_NONE     = 3'd0,
    C_ALERT    = 3'd1,
    C_EARLY    = 3'd2,
    C_TIMEOUT  = 3'd3,
    C_SPURIOUS = 3'd4,
    C_ILLEGAL  = 3'd5
  } mon_cause_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: loadable up-counter that sticks at MAX
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_o <= '0;
    else if (clear_i) q_o <= '0;
    else if (load_i) q_o <= d_i;
    else if (inc_i && q_o != MAX_Q) q_o <= q_o + WIDTH'(1);
endmodule

// File: rtl/done_monitor.sv
// done_monitor: measures start-to-done latency and classifies each sequencer run
module done_monitor
  import done_monitor_pkg::*;
#(
  parameter int MIN_LAT = 14,
  parameter int TIMEOUT = 20,
  localparam int LW     = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  done_i,
  input  logic                  alert_i,
  input  logic                  clr_i,
  output logic                  busy_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic [2:0]            cause_o,
  output logic [LW-1:0]         lat_o,
  output logic [FAIL_CNT_W-1:0] fail_cnt_o
);
  localparam logic [LW-1:0] MIN_L = LW'(MIN_LAT);
  localparam logic [LW-1:0] TO_L  = LW'(TIMEOUT);
  mon_state_e    r_state, w_nxt_state;
  mon_cause_e    r_cause, w_nxt_cause;
  logic [LW-1:0] r_lat_o, w_lat;
  logic          w_lat_load, w_lat_inc, w_fail_inc;
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cause = r_cause;
    case (r_state)
      S_IDLE:
        if (alert_i) begin
          w_nxt_state = S_FAIL;
          w_nxt_cause = C_ALERT;
        end else if (!clr_i && done_i) begin
          w_nxt_state = S_FAIL;
          w_nxt_cause = C_SPURIOUS;
        end else if (!clr_i && start_i) w_nxt_state = S_WAIT;
      S_WAIT:
        if (alert_i) begin
          w_nxt_state = S_FAIL;
          w_nxt_cause = C_ALERT;
        end else if (clr_i) w_nxt_state = S_IDLE;
        else if (done_i) begin
          w_nxt_state = w_lat < MIN_L ? S_FAIL : S_PASS;
          w_nxt_cause = w_lat < MIN_L ? C_EARLY : r_cause;
        end else if (w_lat == TO_L) begin
          w_nxt_state = S_FAIL;
          w_nxt_cause = C_TIMEOUT;
        end
      S_PASS:
        if (alert_i) begin
          w_nxt_state = S_FAIL;
          w_nxt_cause = C_ALERT;
        end else if (clr_i) w_nxt_state = S_IDLE;
        else if (done_i) begin
          w_nxt_state = S_FAIL;
          w_nxt_cause = C_SPURIOUS;
        end
      S_FAIL:
        if (clr_i) begin
          w_nxt_state = alert_i ? S_FAIL : S_IDLE;
          w_nxt_cause = alert_i ? C_ALERT : C_NONE;
        end
      default: begin
        w_nxt_state = S_FAIL;
        w_nxt_cause = C_ILLEGAL;
      end
    endcase
  end
  assign w_fail_inc = w_nxt_state == S_FAIL && r_state != S_FAIL;
  assign w_lat_load = r_state == S_IDLE && w_nxt_state == S_WAIT;
  assign w_lat_inc  = r_state == S_WAIT && w_nxt_state == S_WAIT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cause <= C_NONE;
      r_lat_o <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cause <= w_nxt_cause;
      if (r_state == S_WAIT && w_nxt_state == S_PASS) r_lat_o <= w_lat;
    end
  sat_counter #(.WIDTH(LW), .MAX(TIMEOUT)) u_lat (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(1'b0),
    .load_i (w_lat_load),
    .inc_i  (w_lat_inc),
    .d_i    (LW'(1)),
    .q_o    (w_lat)
  );
  sat_counter #(.WIDTH(FAIL_CNT_W), .MAX((1 << FAIL_CNT_W) - 1)) u_fail_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(1'b0),
    .load_i (1'b0),
    .inc_i  (w_fail_inc),
    .d_i    ('0),
    .q_o    (fail_cnt_o)
  );
  assign busy_o  = r_state == S_WAIT;
  assign pass_o  = r_state == S_PASS;
  assign fail_o  = r_state == S_FAIL;
  assign cause_o = fail_o ? r_cause : C_NONE;
  assign lat_o   = r_lat_o;
endmodule

// File: tb/tb_done_monitor.sv
// tb_done_monitor: random and directed runs checked against an edge-indexed behavioural model
module tb_done_monitor;
  import done_monitor_pkg::*;
  localparam int MIN_LAT = 14;
  localparam int TIMEOUT = 20;
  localparam int LW      = $clog2(TIMEOUT + 1);
  logic          clk = 0, rst_n = 0;
  logic          start_i = 0, done_i = 0, alert_i = 0, clr_i = 0;
  logic          busy_o, pass_o, fail_o;
  logic [2:0]    cause_o;
  logic [LW-1:0] lat_o;
  logic [7:0]    fail_cnt_o;
  int            total = 0, bad = 0;
  bit            cmp_en = 0, inj = 0;
  always #5 clk = ~clk;
  done_monitor #(.MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .done_i    (done_i),
    .alert_i   (alert_i),
    .clr_i     (clr_i),
    .busy_o    (busy_o),
    .pass_o    (pass_o),
    .fail_o    (fail_o),
    .cause_o   (cause_o),
    .lat_o     (lat_o),
    .fail_cnt_o(fail_cnt_o)
  );
  // model phases: 0 idle, 1 waiting, 2 passed, 3 failed; latency = edges since the start edge
  int m_st, m_cause, m_lat_o, m_cnt, m_s, k;
  int n_st, n_cause, n_lat_o, n_cnt, n_s, lat;
  always_comb begin
    lat     = k + 1 - m_s;
    n_st    = m_st;
    n_cause = m_cause;
    n_lat_o = m_lat_o;
    n_s     = m_s;
    if (inj) begin
      n_st    = 3;
      n_cause = 5;
    end else
      case (m_st)
        0:
          if (alert_i) begin n_st = 3; n_cause = 1; end
          else if (!clr_i && done_i) begin n_st = 3; n_cause = 4; end
          else if (!clr_i && start_i) begin n_st = 1; n_s = k + 1; end
        1:
          if (alert_i) begin n_st = 3; n_cause = 1; end
          else if (clr_i) n_st = 0;
          else if (done_i && lat < MIN_LAT) begin n_st = 3; n_cause = 2; end
          else if (done_i) begin n_st = 2; n_lat_o = lat; end
          else if (lat == TIMEOUT) begin n_st = 3; n_cause = 3; end
        2:
          if (alert_i) begin n_st = 3; n_cause = 1; end
          else if (clr_i) n_st = 0;
          else if (done_i) begin n_st = 3; n_cause = 4; end
        default:
          if (clr_i) begin
            n_st    = alert_i ? 3 : 0;
            n_cause = alert_i ? 1 : 0;
          end
      endcase
    n_cnt = (n_st == 3 && (m_st != 3 || inj)) ? (m_cnt >= 255 ? 255 : m_cnt + 1) : m_cnt;
  end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_st <= 0; m_cause <= 0; m_lat_o <= 0; m_cnt <= 0; m_s <= 0; k <= 0;
    end else begin
      m_st <= n_st; m_cause <= n_cause; m_lat_o <= n_lat_o; m_cnt <= n_cnt; m_s <= n_s; k <= k + 1;
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (cmp_en) begin
      chk("busy", busy_o, m_st == 1);
      chk("pass", pass_o, m_st == 2);
      chk("fail", fail_o, m_st == 3);
      chk("cause", cause_o, m_st == 3 ? m_cause : 0);
      chk("lat", lat_o, m_lat_o);
      chk("fail_cnt", fail_cnt_o, m_cnt);
    end
  task automatic drive(input bit s, input bit d, input bit a, input bit c);
    @(negedge clk);
    #1;
    start_i = s; done_i = d; alert_i = a; clr_i = c;
  endtask
  task automatic run_to(input int l);
    drive(1, 0, 0, 0);
    repeat (l - 1) drive(0, 0, 0, 0);
  endtask
  task automatic settle;
    @(posedge clk);
    #2;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #12;
    chk("rst_busy", busy_o, 0); chk("rst_pass", pass_o, 0); chk("rst_fail", fail_o, 0);
    chk("rst_cause", cause_o, 0); chk("rst_lat", lat_o, 0); chk("rst_cnt", fail_cnt_o, 0);
    @(negedge clk); #1; rst_n = 1; cmp_en = 1;
    run_to(14); drive(0, 1, 0, 0); settle;
    chk("nom_pass", pass_o, 1); chk("nom_lat", lat_o, 14); chk("nom_cnt", fail_cnt_o, 0);
    drive(0, 0, 0, 1); settle; chk("nom_idle", pass_o, 0);
    run_to(13); drive(0, 1, 0, 0); settle;
    chk("early_fail", fail_o, 1); chk("early_cause", cause_o, 2); chk("early_cnt", fail_cnt_o, 1);
    drive(0, 0, 0, 1); settle; chk("early_clr_cause", cause_o, 0); chk("early_clr_fail", fail_o, 0);
    run_to(5); drive(0, 0, 1, 0); settle; chk("alert_cause", cause_o, 1);
    drive(0, 0, 1, 1); settle; chk("alert_hold_fail", fail_o, 1); chk("alert_hold_cnt", fail_cnt_o, 2);
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0); settle; chk("spur_idle_cause", cause_o, 4); chk("spur_idle_cnt", fail_cnt_o, 3);
    drive(0, 0, 0, 1);
    run_to(14); drive(0, 1, 0, 0); drive(0, 1, 0, 0); settle;
    chk("spur_pass_cause", cause_o, 4); chk("spur_pass_cnt", fail_cnt_o, 4);
    drive(0, 0, 0, 1);
    run_to(14); drive(0, 1, 1, 0); settle; chk("alert_done_cause", cause_o, 1);
    drive(0, 0, 0, 1);
    run_to(15); drive(0, 1, 0, 1); settle;
    chk("clr_done_busy", busy_o, 0); chk("clr_done_fail", fail_o, 0); chk("clr_done_pass", pass_o, 0);
    drive(1, 0, 0, 0); repeat (19) drive(0, 0, 0, 0); settle;
    chk("to_not_yet", fail_o, 0); chk("to_busy", busy_o, 1);
    drive(0, 0, 0, 0); settle; chk("to_fail", fail_o, 1); chk("to_cause", cause_o, 3);
    repeat (3) drive(1, 1, 0, 0); settle;
    chk("to_hold_cause", cause_o, 3); chk("to_hold_cnt", fail_cnt_o, 6);
    drive(0, 0, 0, 1);
    for (int l = 1; l <= TIMEOUT; l++) begin
      run_to(l); drive(0, 1, 0, 0); drive(0, 0, 0, 1);
    end
    run_to(TIMEOUT); drive(0, 1, 0, 0); settle; chk("max_pass", pass_o, 1); chk("max_lat", lat_o, TIMEOUT);
    drive(0, 0, 0, 1);
    @(negedge clk); #1;
    start_i = 0; done_i = 0; alert_i = 0; clr_i = 0;
    force dut.r_state = mon_state_e'(4'b1111);
    inj = 1;
    #1 release dut.r_state;
    settle; inj = 0;
    chk("illegal_fail", fail_o, 1); chk("illegal_cause", cause_o, 5);
    drive(0, 0, 0, 1);
    run_to(10); settle; chk("pre_rst_busy", busy_o, 1);
    rst_n = 0; #1;
    chk("arst_busy", busy_o, 0); chk("arst_fail", fail_o, 0); chk("arst_lat", lat_o, 0);
    chk("arst_cnt", fail_cnt_o, 0); chk("arst_cause", cause_o, 0);
    start_i = 0;
    @(negedge clk); #1; rst_n = 1;
    repeat (3000)
      drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 7,
            $urandom_range(0, 199) < 3, $urandom_range(0, 99) < 6);
    drive(0, 0, 0, 1);
    repeat (300) begin
      drive(0, 1, 0, 0); drive(0, 0, 0, 1);
    end
    settle; chk("sat_cnt", fail_cnt_o, 255);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
